dfm_responder: RTL and testbench

Synthesizable data-memory (DFM) responder that serves the CPU's data port: dfm_req_addr, dfm_wr_en, dfm_wr_data in; dfm_rd_data out. It replaces the behavioural DFM model at the subsystem level.
- Decodes the DFM region.
- Holds a single-port word RAM with registered, read-before-write access.
- Clears the RAM after reset with an init state machine.
- Flags illegal accesses through a sticky error with a captured address.

---
 rtl/dfm_responder_pkg.sv | 30 +++
 rtl/dfm_responder_sram.sv | 31 +++
 rtl/dfm_responder.sv | 138 +++++++++++++
 tb/tb_dfm_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dfm_responder_pkg.sv
// Shared types, constants and the address-legality rule for the DFM responder.
// The design and any scoreboard use the same legality function.
package pkg_dfm;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } dfm_state_t;

  localparam logic [3:0] DFM_REGION_TAG = 4'b0001;

  // A legal access has the region tag, no set bits above the index field and word alignment.
  function automatic logic dfm_addr_legal(
    input logic [31:0] addr,
    input logic [3:0]  tag,
    input int unsigned idx_w
  );
    logic [27:0] above_idx;
    above_idx = addr[27:0] >> (2 + idx_w);
    return (addr[31:28] == tag) && (above_idx == 28'd0) && (addr[1:0] == 2'b00);
  endfunction

  function automatic logic dfm_tag_hit(
    input logic [31:0] addr,
    input logic [3:0]  tag
  );
    return addr[31:28] == tag;
  endfunction

endpackage

// File: rtl/dfm_responder_sram.sv
// Single-port word RAM with registered read and read-before-write behaviour.
// Kept free of reset so a vendor macro can replace it directly.
module dfm_sram_1rw #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // The read captures the old word even when the same edge writes it.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dfm_responder.sv
// Data-memory responder for the CPU data port: region decode, cleared word RAM,
// and a sticky illegal-access flag with the address of the first fault.
module dfm_responder
  import pkg_dfm::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         MEM_DEPTH  = 1024,
  parameter logic [3:0] REGION_TAG = DFM_REGION_TAG,
  parameter bit         INIT_CLEAR = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [ADDR_WIDTH-1:0] dfm_req_addr,
  input  logic                  dfm_wr_en,
  input  logic [DATA_WIDTH-1:0] dfm_wr_data,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] dfm_rd_data,
  output logic                  dfm_ready,
  output logic                  dfm_err,
  output logic [ADDR_WIDTH-1:0] dfm_err_addr
);

  localparam int               IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] CNT_LAST  = IDX_W'(MEM_DEPTH - 1);
  localparam dfm_state_t       RST_STATE = (INIT_CLEAR != 1'b0) ? S_INIT : S_READY;

  generate
    if (ADDR_WIDTH != 32) begin : g_bad_aw
      $error("dfm_responder: ADDR_WIDTH must be 32");
    end
    if ((MEM_DEPTH < 2) || (MEM_DEPTH != (1 << IDX_W)) || (IDX_W > 26)) begin : g_bad_depth
      $error("dfm_responder: MEM_DEPTH must be a power of two in 2..2^26");
    end
  endgenerate

  dfm_state_t            state_q;
  logic [IDX_W-1:0]      cnt_q;
  logic                  ready_q;
  logic                  rd_valid_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  logic                  addr_legal;
  logic                  tag_hit;
  logic                  fault;
  logic [IDX_W-1:0]      req_idx;

  logic                  ram_en;
  logic                  ram_we;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign addr_legal = dfm_addr_legal(dfm_req_addr[31:0], REGION_TAG, IDX_W);
  assign tag_hit    = dfm_tag_hit(dfm_req_addr[31:0], REGION_TAG);
  assign req_idx    = dfm_req_addr[2+IDX_W-1:2];
  // A tag miss belongs to another slave; only in-region garbage is a fault.
  assign fault      = (state_q == S_READY) && tag_hit && !addr_legal;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_idx;
    ram_wdata = dfm_wr_data;
    if (state_q == S_INIT) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = cnt_q;
      ram_wdata = '0;
    end else begin
      ram_en    = addr_legal;
      ram_we    = addr_legal && dfm_wr_en;
    end
  end

  dfm_sram_1rw #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk_i   (sys_clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          rd_valid_q <= 1'b0;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end
        end
        S_READY: begin
          ready_q    <= 1'b1;
          rd_valid_q <= addr_legal;
        end
        default: begin
          state_q <= RST_STATE;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase

      // A fault on the same edge as err_clr wins and re-captures its own address.
      if (fault) begin
        err_q <= 1'b1;
        if (!err_q || err_clr) begin
          err_addr_q <= dfm_req_addr;
        end
      end else if (err_clr) begin
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end
    end
  end

  // The RAM output register is not reset, so a registered valid gates it to zero.
  assign dfm_rd_data  = rd_valid_q ? ram_rdata : '0;
  assign dfm_ready    = ready_q;
  assign dfm_err      = err_q;
  assign dfm_err_addr = err_addr_q;

endmodule

// File: tb/tb_dfm_responder.sv
// Randomized bench for dfm_responder against a word-array reference model
// built from the address-decode and error rules.
module tb_dfm_responder;

  localparam int DEPTH = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] dfm_req_addr = '0;
  logic        dfm_wr_en = 1'b0;
  logic [31:0] dfm_wr_data = '0;
  logic        err_clr = 1'b0;
  logic [31:0] dfm_rd_data;
  logic        dfm_ready;
  logic        dfm_err;
  logic [31:0] dfm_err_addr;

  dfm_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (DEPTH),
    .REGION_TAG (4'b0001),
    .INIT_CLEAR (1'b1)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .dfm_req_addr (dfm_req_addr),
    .dfm_wr_en    (dfm_wr_en),
    .dfm_wr_data  (dfm_wr_data),
    .err_clr      (err_clr),
    .dfm_rd_data  (dfm_rd_data),
    .dfm_ready    (dfm_ready),
    .dfm_err      (dfm_err),
    .dfm_err_addr (dfm_err_addr)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem_m [DEPTH];
  logic        err_m;
  logic [31:0] err_addr_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input logic [31:0] a);
    return ((a >> 28) == 32'd1) && (((a >> 12) & 32'h0000_FFFF) == 32'd0) && ((a % 4) == 32'd0);
  endfunction

  function automatic bit model_fault(input logic [31:0] a);
    return ((a >> 28) == 32'd1) && !model_legal(a);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    err_m      = 1'b0;
    err_addr_m = '0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, ".rd"},      dfm_rd_data, 32'd0);
    check_eq({tag, ".ready"},   32'(dfm_ready), 32'd0);
    check_eq({tag, ".err"},     32'(dfm_err), 32'd0);
    check_eq({tag, ".erraddr"}, dfm_err_addr, 32'd0);
  endtask

  // One request; called right after a falling edge, returns after the next one.
  task automatic access(input logic [31:0] a, input bit we, input logic [31:0] d,
                        input bit clr, input string tag);
    logic [31:0] rd_m;
    int          idx;
    dfm_req_addr = a;
    dfm_wr_en    = we;
    dfm_wr_data  = d;
    err_clr      = clr;
    @(posedge sys_clk);
    rd_m = '0;
    idx  = int'((a >> 2) % DEPTH);
    if (model_legal(a)) begin
      rd_m = mem_m[idx];
      if (we) mem_m[idx] = d;
    end
    if (model_fault(a)) begin
      if (!err_m || clr) err_addr_m = a;
      err_m = 1'b1;
    end else if (clr) begin
      err_m      = 1'b0;
      err_addr_m = '0;
    end
    @(negedge sys_clk);
    $display("%s addr=%08h we=%0d wd=%08h clr=%0d -> rd=%08h err=%0d eaddr=%08h",
             tag, a, we, d, clr, dfm_rd_data, dfm_err, dfm_err_addr);
    check_eq({tag, ".rd"},      dfm_rd_data, rd_m);
    check_eq({tag, ".err"},     32'(dfm_err), 32'(err_m));
    check_eq({tag, ".erraddr"}, dfm_err_addr, err_addr_m);
    check_eq({tag, ".ready"},   32'(dfm_ready), 32'd1);
    dfm_wr_en = 1'b0;
    err_clr   = 1'b0;
  endtask

  // Counts init edges from release; CPU traffic during init must have no effect.
  task automatic wait_init(input string tag);
    dfm_req_addr = 32'h1000_1000;
    dfm_wr_en    = 1'b1;
    dfm_wr_data  = 32'h0000_1234;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (i == DEPTH / 2) dfm_req_addr = 32'h1000_0000;
      if (i == 1)         check_eq({tag, ".rd_during"}, dfm_rd_data, 32'd0);
      if (i == DEPTH - 1) check_eq({tag, ".ready_early"}, 32'(dfm_ready), 32'd0);
      if (i == DEPTH)     check_eq({tag, ".ready_on_time"}, 32'(dfm_ready), 32'd1);
    end
    check_eq({tag, ".err_after"}, 32'(dfm_err), 32'd0);
    $display("%s init complete", tag);
    dfm_wr_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 99);
    if (r < 60) begin
      a = 32'h1000_0000 | ($urandom_range(0, 15) << 2);
    end else if (r < 75) begin
      a = $urandom;
      if (a[31:28] == 4'h1) a[31:28] = 4'h3;
    end else if (r < 90) begin
      a = 32'h1000_0000 | ($urandom_range(1, 16'hFFFF) << 12) | ($urandom_range(0, 15) << 2);
    end else begin
      a = 32'h1000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
    end
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_model();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset("reset");
    sys_rst_n = 1'b1;
    wait_init("init1");

    access(32'h1000_0010, 1'b0, 32'h0,         1'b0, "t1_rd_cleared");
    access(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 1'b0, "t2_wr_old");
    access(32'h1000_0004, 1'b0, 32'h0,         1'b0, "t2_rd_new");
    access(32'h2000_0000, 1'b1, 32'h5555_5555, 1'b0, "t3_foreign");
    access(32'h1000_0000, 1'b0, 32'h0,         1'b0, "t3_readback");
    access(32'h1000_1000, 1'b0, 32'h0,         1'b0, "t4_oor");
    access(32'h1000_0002, 1'b1, 32'h7777_7777, 1'b0, "t4_misalign");
    access(32'h1000_0000, 1'b0, 32'h0,         1'b1, "t4_clear");
    access(32'h1000_2000, 1'b0, 32'h0,         1'b0, "t5_prefault");
    access(32'h1000_0003, 1'b0, 32'h0,         1'b1, "t5_clr_vs_fault");
    access(32'h1000_0000, 1'b0, 32'h0,         1'b1, "t5_clear");

    for (int n = 0; n < 400; n++) begin
      access(rand_addr(), 1'($urandom_range(0, 1)), $urandom,
             ($urandom_range(0, 15) == 0), "rand");
    end

    access(32'h1000_0008, 1'b1, 32'hA5A5_A5A5, 1'b0, "t6_wr");
    access(32'h1000_0008, 1'b0, 32'h0,         1'b0, "t6_rd");
    access(32'h1000_4000, 1'b0, 32'h0,         1'b0, "t6_fault");
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_reset("t6_async_reset");
    @(negedge sys_clk);
    sys_rst_n    = 1'b1;
    dfm_req_addr = 32'h1000_0000;
    dfm_wr_en    = 1'b1;
    dfm_wr_data  = 32'h0000_1234;
    repeat (500) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    sys_rst_n = 1'b0;
    #1;
    check_reset("t6_reset_mid_init");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_model();
    wait_init("init3");
    access(32'h1000_0000, 1'b0, 32'h0, 1'b0, "t6_init_write_absent");
    access(32'h1000_0008, 1'b0, 32'h0, 1'b0, "t6_recleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
